// File: rtl/fetch_stage.sv
// Instruction-fetch front end: credit-limited request issue to instruction memory,
// in-order response capture into a prefetch FIFO, and redirect flush with stale-response dropping.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [XLEN-1:0]        imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [XLEN-1:0]        if_instr,
  output logic [XLEN-1:0]        if_pc,
  output logic [XLEN-1:0]        if_pc_4,
  output logic [$clog2(DEPTH):0] outstanding
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_tgt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   out_after_rsp;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW:0]     in_use;
  logic            req_fire;
  logic            rsp_dec;
  logic            push;
  logic            pop;

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  // Handshakes and head-of-FIFO outputs
  always_comb begin
    in_use         = (CW+1)'(count) + (CW+1)'(outstanding);
    imem_req_valid = reset && (in_use < (CW+1)'(DEPTH)) && !redirect_valid;
    imem_addr      = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_dec        = imem_rsp_valid && (outstanding != '0);
    out_after_rsp  = outstanding - CW'(rsp_dec);
    push           = imem_rsp_valid && (drop == '0) && !redirect_valid;
    if_valid       = reset && (count != '0) && !redirect_valid;
    pop            = if_valid && if_ready;
    if_instr       = instr_mem[rd_ptr];
    if_pc          = pc_mem[rd_ptr];
    if_pc_4        = pc_mem[rd_ptr] + XLEN'(4);
    redirect_tgt   = {redirect_pc[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_tgt;
      rsp_pc      <= redirect_tgt;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= out_after_rsp;
      // Every request still in flight is stale; drop already covers a subset of them.
      drop        <= out_after_rsp;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= out_after_rsp + CW'(req_fire);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents only matter while count != 0
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]    <= rsp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && (count == CW'(DEPTH))))
    else $error("fetch_stage: response pushed into full FIFO");

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order memory model plus a queue-based
// reference of in-flight requests and decode-visible entries.
module tb_fetch_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [31:0]     imem_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            redirect_valid = 1'b0;
  logic [31:0]     redirect_pc = '0;
  logic            if_valid;
  logic            if_ready = 1'b0;
  logic [31:0]     if_instr;
  logic [31:0]     if_pc;
  logic [31:0]     if_pc_4;
  logic [CW-1:0]   outstanding;

  fetch_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_4(if_pc_4), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  req_t        mem_q[$];
  ent_t        fifo_q[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] dut_popped[$];
  int          dut_fires;
  int          cyc;
  int          n_tests;
  int          n_fail;

  bit          s_if_ready, s_req_ready, s_rsp_en, s_redir;
  logic [31:0] s_redir_pc;
  int          s_lat = 1;

  logic        smp_req_valid, smp_ifv;
  logic [31:0] smp_addr, smp_pc;
  logic [31:0] smp_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus, per-cycle comparison against the model, then model update
  task automatic tick();
    bit   rsp, e_req, e_ifv, fire, pop;
    req_t r;
    ent_t e;
    @(negedge clk);
    rsp = s_rsp_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? (mem_q[0].addr ^ KEY) : $urandom;
    imem_req_ready = s_req_ready;
    if_ready       = s_if_ready;
    redirect_valid = s_redir;
    redirect_pc    = s_redir_pc;
    #1;
    e_req = ((fifo_q.size() + mem_q.size()) < DEPTH) && !s_redir;
    e_ifv = (fifo_q.size() != 0) && !s_redir;
    chk("imem_req_valid", 32'(imem_req_valid), 32'(e_req));
    chk("imem_addr", imem_addr, m_fetch_pc);
    chk("if_valid", 32'(if_valid), 32'(e_ifv));
    chk("outstanding", 32'(outstanding), 32'(mem_q.size()));
    if (e_ifv) begin
      chk("if_instr", if_instr, fifo_q[0].instr);
      chk("if_pc", if_pc, fifo_q[0].pc);
      chk("if_pc_4", if_pc_4, fifo_q[0].pc + 32'd4);
    end
    smp_req_valid = imem_req_valid;
    smp_addr      = imem_addr;
    smp_ifv       = if_valid;
    smp_pc        = if_pc;
    smp_out       = 32'(outstanding);
    if (if_valid && s_if_ready) dut_popped.push_back(if_pc);
    if (imem_req_valid && s_req_ready) dut_fires++;

    fire = e_req && s_req_ready;
    pop  = e_ifv && s_if_ready;
    if (rsp) begin
      r = mem_q.pop_front();
      if (!r.stale && !s_redir) begin
        e.instr = r.addr ^ KEY;
        e.pc    = r.addr;
        fifo_q.push_back(e);
      end
    end
    if (s_redir) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      fifo_q.delete();
      m_fetch_pc = s_redir_pc & ~32'h3;
    end else begin
      if (pop) void'(fifo_q.pop_front());
      if (fire) begin
        r.addr  = m_fetch_pc;
        r.due   = cyc + s_lat;
        r.stale = 1'b0;
        mem_q.push_back(r);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic quiet_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    s_if_ready = 0; s_req_ready = 0; s_rsp_en = 0; s_redir = 0; s_redir_pc = '0; s_lat = 1;
  endtask

  task automatic flush_model();
    mem_q.delete();
    fifo_q.delete();
    m_fetch_pc = RESET_PC;
    dut_popped.delete();
    dut_fires = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    quiet_inputs();
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    repeat (n) @(posedge clk);
    flush_model();
    #2 reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    quiet_inputs();

    // Reset then stream
    do_reset(3);
    s_req_ready = 1; s_if_ready = 1; s_rsp_en = 1; s_lat = 1;
    tick();
    chk("first_req_valid", 32'(smp_req_valid), 32'd1);
    chk("first_req_addr", smp_addr, 32'h0);
    repeat (8) tick();
    chk("stream_pops", 32'(dut_popped.size() >= 4), 32'd1);
    if (dut_popped.size() >= 4) begin
      chk("stream_pc0", dut_popped[0], 32'h0);
      chk("stream_pc1", dut_popped[1], 32'h4);
      chk("stream_pc2", dut_popped[2], 32'h8);
      chk("stream_pc3", dut_popped[3], 32'hC);
    end

    // Backpressure fills the FIFO and stops issue
    do_reset(2);
    s_req_ready = 1; s_if_ready = 0; s_rsp_en = 1; s_lat = 1;
    repeat (10) tick();
    chk("bp_fires", 32'(dut_fires), 32'd4);
    chk("bp_req_valid", 32'(smp_req_valid), 32'd0);
    chk("bp_outstanding", smp_out, 32'd0);
    chk("bp_if_valid", 32'(smp_ifv), 32'd1);
    s_if_ready = 1;
    tick();
    chk("bp_pop_pc", smp_pc, 32'h0);
    s_if_ready = 0;
    tick();
    chk("bp_refill_valid", 32'(smp_req_valid), 32'd1);
    chk("bp_refill_addr", smp_addr, 32'h10);
    chk("bp_fires_after", 32'(dut_fires), 32'd5);

    // Redirect with two requests in flight
    do_reset(2);
    s_req_ready = 1; s_if_ready = 1; s_rsp_en = 0;
    repeat (2) tick();
    s_req_ready = 0; s_redir = 1; s_redir_pc = 32'h0000_0103;
    tick();
    chk("redir_if_valid", 32'(smp_ifv), 32'd0);
    chk("redir_req_valid", 32'(smp_req_valid), 32'd0);
    s_redir = 0; s_req_ready = 1; s_rsp_en = 1;
    tick();
    chk("redir_target_addr", smp_addr, 32'h100);
    repeat (6) tick();
    chk("redir_first_pc", (dut_popped.size() > 0) ? dut_popped[0] : 32'hDEAD_BEEF, 32'h100);

    // Redirect coinciding with a response, three in flight
    do_reset(2);
    s_req_ready = 1; s_if_ready = 1; s_rsp_en = 0;
    repeat (3) tick();
    s_req_ready = 0; s_rsp_en = 1; s_redir = 1; s_redir_pc = 32'h0000_0200;
    tick();
    s_redir = 0; s_rsp_en = 0;
    tick();
    chk("rsp_redir_outstanding", smp_out, 32'd2);
    s_req_ready = 1; s_rsp_en = 1;
    repeat (8) tick();
    chk("rsp_redir_first_pc", (dut_popped.size() > 0) ? dut_popped[0] : 32'hDEAD_BEEF, 32'h200);

    // Redirect in the same cycle decode would pop
    do_reset(2);
    s_req_ready = 1; s_if_ready = 0; s_rsp_en = 1; s_lat = 1;
    repeat (4) tick();
    s_if_ready = 1; s_rsp_en = 0; s_req_ready = 0; s_redir = 1; s_redir_pc = 32'h0000_0300;
    tick();
    chk("pop_redir_no_pop", 32'(dut_popped.size()), 32'd0);
    s_redir = 0; s_req_ready = 1;
    tick();
    chk("pop_redir_empty", 32'(smp_ifv), 32'd0);
    chk("pop_redir_addr", smp_addr, 32'h300);
    chk("pop_redir_req_valid", 32'(smp_req_valid), 32'd1);

    // Asynchronous reset mid-operation
    do_reset(2);
    s_req_ready = 1; s_if_ready = 0; s_lat = 1;
    for (int i = 0; i < 20; i++) begin
      if (fifo_q.size() == 3 && mem_q.size() == 1) break;
      s_rsp_en = (fifo_q.size() < 3);
      tick();
    end
    chk("mid_setup_reached", 32'(fifo_q.size() == 3 && mem_q.size() == 1), 32'd1);
    @(negedge clk);
    quiet_inputs();
    #1;
    chk("mid_pre_if_valid", 32'(if_valid), 32'd1);
    chk("mid_pre_outstanding", 32'(outstanding), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_if_valid", 32'(if_valid), 32'd0);
    chk("mid_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_outstanding", 32'(outstanding), 32'd0);
    repeat (2) @(posedge clk);
    flush_model();
    #2 reset = 1'b1;
    s_req_ready = 1; s_rsp_en = 1; s_if_ready = 1; s_lat = 1;
    tick();
    chk("mid_restart_valid", 32'(smp_req_valid), 32'd1);
    chk("mid_restart_addr", smp_addr, RESET_PC);

    // Randomised traffic, including redirects near the top of the address space
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      s_lat       = 1 + int'($urandom_range(2, 0));
      s_req_ready = ($urandom_range(3, 0) != 0);
      s_if_ready  = ($urandom_range(2, 0) != 0);
      s_rsp_en    = ($urandom_range(3, 0) != 0);
      s_redir     = ($urandom_range(19, 0) == 0);
      s_redir_pc  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                 : 32'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
